// File: rtl/video_timing_detect.sv
// Receive-side timing detector: measures line/frame totals and active sizes of an
// incoming hsync/vsync/de stream, locks once stable, and regenerates x/y coordinates.
module video_timing_detect #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic          locked,
    output logic          err
);

    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] CMAX_M1 = CMAX - 1'b1;
    localparam logic [3:0]    LF      = 4'(LOCK_FRAMES);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic hsync_q, hsync_qq;
    logic vsync_q, vsync_qq;
    logic de_q, de_qq;

    logic hs_rise, vs_rise, de_rise, de_fall;

    logic [CW-1:0] hper;
    logic [CW-1:0] h_line;
    logic [CW-1:0] hact;
    logic [CW-1:0] h_act_cur;
    logic [CW-1:0] vper;
    logic [CW-1:0] vact;
    logic          frame_bad;
    logic          first_line;
    logic [3:0]    match_cnt;

    logic [CW-1:0] hper_inc;
    logic [CW-1:0] h_line_nxt;
    logic [CW-1:0] h_act_cur_nxt;
    logic [CW-1:0] vper_nxt;
    logic [CW-1:0] vact_nxt;
    logic          line_bad;
    logic          frame_bad_nxt;
    logic          cand_match;
    logic [3:0]    match_cnt_inc;
    logic          loss;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q  <= 1'b0;
            hsync_qq <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            de_q     <= 1'b0;
            de_qq    <= 1'b0;
        end else begin
            hsync_q  <= hsync;
            hsync_qq <= hsync_q;
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            de_q     <= de;
            de_qq    <= de_q;
        end
    end

    assign hs_rise = hsync_q & ~hsync_qq;
    assign vs_rise = vsync_q & ~vsync_qq;
    assign de_rise = de_q & ~de_qq;
    assign de_fall = ~de_q & de_qq;

    // Primed values fold in a strobe landing in the same cycle as vs_rise, so an
    // hs edge coincident with vsync is credited to the frame that is finishing.
    always_comb begin
        hper_inc      = sat_inc(hper);
        h_line_nxt    = hs_rise ? hper_inc : h_line;
        line_bad      = hs_rise && (vper != '0) && (hper_inc != h_line);
        frame_bad_nxt = frame_bad | line_bad;
        vper_nxt      = hs_rise ? sat_inc(vper) : vper;
        vact_nxt      = de_rise ? sat_inc(vact) : vact;
        h_act_cur_nxt = de_fall ? hact : h_act_cur;
        cand_match    = (h_line_nxt == h_total) && (h_act_cur_nxt == h_active) &&
                        (vper_nxt == v_total) && (vact_nxt == v_active) &&
                        (h_line_nxt != '0) && (h_act_cur_nxt != '0) &&
                        (vper_nxt != '0) && (vact_nxt != '0) && !frame_bad_nxt;
        match_cnt_inc = (match_cnt >= LF) ? LF : match_cnt + 4'd1;
        loss          = !hs_rise && (hper == CMAX_M1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hper      <= '0;
            h_line    <= '0;
            hact      <= '0;
            h_act_cur <= '0;
            vper      <= '0;
            vact      <= '0;
            frame_bad <= 1'b0;
        end else begin
            hper      <= hs_rise ? '0 : hper_inc;
            h_line    <= h_line_nxt;
            h_act_cur <= h_act_cur_nxt;
            if (de_rise)
                hact <= {{(CW-1){1'b0}}, 1'b1};
            else if (de_q)
                hact <= sat_inc(hact);
            if (vs_rise) begin
                vper      <= '0;
                vact      <= '0;
                frame_bad <= 1'b0;
            end else begin
                vper      <= vper_nxt;
                vact      <= vact_nxt;
                frame_bad <= frame_bad_nxt;
            end
        end
    end

    // Signal loss is applied after the frame update so it overrides a same-cycle lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_total   <= '0;
            h_active  <= '0;
            v_total   <= '0;
            v_active  <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (vs_rise) begin
                h_total  <= h_line_nxt;
                h_active <= h_act_cur_nxt;
                v_total  <= vper_nxt;
                v_active <= vact_nxt;
                if (cand_match) begin
                    match_cnt <= match_cnt_inc;
                    if (match_cnt_inc == LF)
                        locked <= 1'b1;
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                    err       <= locked;
                end
            end
            if (loss) begin
                match_cnt <= '0;
                locked    <= 1'b0;
                err       <= locked;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            de_o       <= 1'b0;
            hsync_o    <= 1'b0;
            vsync_o    <= 1'b0;
            first_line <= 1'b0;
        end else begin
            de_o    <= de_q;
            hsync_o <= hsync_q;
            vsync_o <= vsync_q;
            if (de_rise)
                x <= '0;
            else if (de_q)
                x <= sat_inc(x);
            if (de_rise) begin
                if (first_line) begin
                    y          <= '0;
                    first_line <= 1'b0;
                end else begin
                    y <= sat_inc(y);
                end
            end
            if (vs_rise)
                first_line <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect using small raster modes so whole frames
// fit in a short run; expected values are hand-derived from the raster geometry.
module tb_video_timing_detect;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsync, vsync, de;
    logic [CW-1:0] x, y;
    logic          hsync_o, vsync_o, de_o;
    logic [CW-1:0] h_total, h_active, v_total, v_active;
    logic          locked, err;

    int vectors     = 0;
    int miscompares = 0;

    // Raster generator state
    int hc, vc, pcnt;
    int ht, ha, hfp, hsw, vt, va, vfp, vsw;
    int stretch_line;
    bit kill;

    video_timing_detect #(.CW(CW), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input int t_ht, input int t_ha, input int t_hfp, input int t_hsw,
                            input int t_vt, input int t_va, input int t_vfp, input int t_vsw);
        ht = t_ht; ha = t_ha; hfp = t_hfp; hsw = t_hsw;
        vt = t_vt; va = t_va; vfp = t_vfp; vsw = t_vsw;
    endtask

    task automatic restart();
        hc = 0; vc = 0; pcnt = 0; stretch_line = -1; kill = 1'b0;
        set_mode(20, 12, 2, 3, 10, 6, 2, 2);
    endtask

    // Drive one pixel, let one clock edge pass, then advance the raster position.
    task automatic pix();
        if (kill) begin
            hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        end else begin
            hsync = (hc >= ha + hfp) && (hc < ha + hfp + hsw);
            vsync = (vc >= va + vfp) && (vc < va + vfp + vsw);
            de    = (hc < ha) && (vc < va);
        end
        @(posedge clk);
        #1;
        pcnt++;
        hc++;
        if (hc == ht + ((vc == stretch_line) ? 1 : 0)) begin
            hc = 0;
            vc++;
            if (vc == vt) begin
                vc = 0;
                stretch_line = -1;
            end
        end
    endtask

    task automatic run_to(input int n);
        while (pcnt < n) pix();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_de_o"}, de_o, 0);
        chk({tag, "_hsync_o"}, hsync_o, 0);
        chk({tag, "_vsync_o"}, vsync_o, 0);
        chk({tag, "_h_total"}, h_total, 0);
        chk({tag, "_h_active"}, h_active, 0);
        chk({tag, "_v_total"}, v_total, 0);
        chk({tag, "_v_active"}, v_active, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Mode A 20x10 (active 12x6): vsync rises on pixel 160 of each 200-pixel frame.
    task automatic lock_sequence(input string tag);
        run_to(161);
        chk({tag, "_vt_before_vs"}, v_total, 0);
        run_to(162);
        chk({tag, "_vt_partial"}, v_total, 8);
        chk({tag, "_ht_f0"}, h_total, 20);
        chk({tag, "_ha_f0"}, h_active, 12);
        chk({tag, "_va_f0"}, v_active, 6);
        chk({tag, "_locked_f0"}, locked, 0);
        run_to(362);
        chk({tag, "_vt_full"}, v_total, 10);
        run_to(761);
        chk({tag, "_locked_pre"}, locked, 0);
        run_to(762);
        chk({tag, "_locked"}, locked, 1);
        chk({tag, "_err_on_lock"}, err, 0);
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        restart();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst = 1'b0;

        lock_sequence("lock_a");
        chk("meas_ht", h_total, 20);
        chk("meas_ha", h_active, 12);
        chk("meas_vt", v_total, 10);
        chk("meas_va", v_active, 6);

        // Coordinates in locked frame 4 (starts at pixel 800)
        run_to(801);
        chk("pre_de_o", de_o, 0);
        chk("pre_x_hold", x, 11);
        chk("pre_y_hold", y, 5);
        run_to(802);
        chk("first_de_o", de_o, 1);
        chk("first_x", x, 0);
        chk("first_y", y, 0);
        run_to(815);
        chk("hsync_o_lo", hsync_o, 0);
        run_to(816);
        chk("hsync_o_hi", hsync_o, 1);
        run_to(913);
        chk("last_de_o", de_o, 1);
        chk("last_x", x, 11);
        chk("last_y", y, 5);
        run_to(914);
        chk("post_de_o", de_o, 0);
        chk("post_x_hold", x, 11);
        run_to(961);
        chk("vsync_o_lo", vsync_o, 0);
        run_to(962);
        chk("vsync_o_hi", vsync_o, 1);
        chk("still_locked", locked, 1);

        // Mode change to 24x12 (active 16x8) at the frame boundary
        run_to(1000);
        set_mode(24, 16, 2, 3, 12, 8, 2, 2);
        run_to(1241);
        chk("mode_err_pre", err, 0);
        chk("mode_locked_pre", locked, 1);
        run_to(1242);
        chk("mode_err", err, 1);
        chk("mode_unlock", locked, 0);
        chk("mode_vt", v_total, 12);
        run_to(1243);
        chk("mode_err_1cyc", err, 0);
        run_to(1817);
        chk("mode_relock_pre", locked, 0);
        run_to(1818);
        chk("mode_relock", locked, 1);
        chk("mode_ht", h_total, 24);
        chk("mode_ha", h_active, 16);
        chk("mode_vt2", v_total, 12);
        chk("mode_va", v_active, 8);

        // One 25-cycle line in the frame starting at pixel 1864
        run_to(1864);
        stretch_line = 3;
        run_to(2106);
        chk("stretch_err_pre", err, 0);
        chk("stretch_locked_pre", locked, 1);
        run_to(2107);
        chk("stretch_err", err, 1);
        chk("stretch_unlock", locked, 0);
        run_to(2108);
        chk("stretch_err_1cyc", err, 0);
        run_to(2682);
        chk("stretch_relock_pre", locked, 0);
        run_to(2683);
        chk("stretch_relock", locked, 1);

        // Inputs dead from pixel 2729; last hsync rise was driven on pixel 2723
        run_to(2729);
        kill = 1'b1;
        run_to(6819);
        chk("loss_err_pre", err, 0);
        chk("loss_locked_pre", locked, 1);
        run_to(6820);
        chk("loss_err", err, 1);
        chk("loss_unlock", locked, 0);
        chk("loss_ht", h_total, 24);
        chk("loss_ha", h_active, 16);
        chk("loss_vt", v_total, 12);
        chk("loss_va", v_active, 8);
        run_to(6821);
        chk("loss_err_1cyc", err, 0);
        chk("loss_stays_unlocked", locked, 0);
        run_to(6830);

        // Resume mode A, lock, then pulse reset mid-frame
        restart();
        run_to(899);
        chk("resume_locked", locked, 1);
        rst = 1'b1;
        pix();
        check_zero("midrst");
        rst = 1'b0;
        restart();
        lock_sequence("relock");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
